reg_file_mp: RTL and testbench

//  Parametrised multi-port register file: NR read ports, NW write ports, DEPTH x WIDTH.

---
 rtl/reg_file_mp_pkg.sv | 8 +
 rtl/reg_file_mp_if.sv | 27 ++
 rtl/reg_file_mp_scoreboard.sv | 40 ++++
 rtl/reg_file_mp.sv | 82 ++++++++
 tb/tb_reg_file_mp.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults for the multi-port register file and its scoreboard.
package reg_file_mp_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 16;
   localparam int DEF_AW    = 4;
   localparam int DEF_NR    = 2;
   localparam int DEF_NW    = 2;
endpackage

// File: rtl/reg_file_mp_if.sv
// Read, write and scoreboard-set bus between the datapath and the register file.
interface reg_file_mp_if #(
   parameter int WIDTH = 16,
   parameter int AW    = 4,
   parameter int NR    = 2,
   parameter int NW    = 2
);
   logic [NR*AW-1:0]    rd_addr;
   logic [NR*WIDTH-1:0] rd_data;
   logic [NR-1:0]       rd_busy;
   logic [NW-1:0]       wr_en;
   logic [NW*AW-1:0]    wr_addr;
   logic [NW*WIDTH-1:0] wr_data;
   logic                sb_set_en;
   logic [AW-1:0]       sb_set_addr;
   logic                any_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      input  rd_data, rd_busy, any_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      output rd_data, rd_busy, any_busy
   );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register pending bits: any write clears, an issue sets, set beats clear on the same register.
module reg_file_mp_scoreboard
   import reg_file_mp_pkg::*;
#(
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AW        = DEF_AW,
   parameter int NW        = DEF_NW,
   parameter bit ZERO_REG0 = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NW-1:0]    wr_en,
   input  logic [NW*AW-1:0] wr_addr,
   input  logic             sb_set_en,
   input  logic [AW-1:0]    sb_set_addr,
   output logic [DEPTH-1:0] busy,
   output logic             any_busy
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int w = 0; w < NW; w++) begin
         if (wr_en[w]) busy_d[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (sb_set_en) busy_d[sb_set_addr] = 1'b1;
      if (ZERO_REG0) busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   assign busy     = busy_q;
   assign any_busy = |busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with write-port priority, optional same-cycle bypass and busy scoreboard.
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int                   WIDTH     = DEF_WIDTH,
   parameter int                   DEPTH     = DEF_DEPTH,
   parameter int                   AW        = $clog2(DEPTH),
   parameter int                   NR        = DEF_NR,
   parameter int                   NW        = DEF_NW,
   parameter bit                   BYPASS    = 1'b1,
   parameter bit                   ZERO_REG0 = 1'b0,
   parameter logic [DEPTH*WIDTH-1:0] RST_VALS = '0
) (
   input logic          clk,
   input logic          rst,
   reg_file_mp_if.slave bus
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;

   // Later ports overwrite earlier ones in the loop, so the highest index wins a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= RST_VALS[i*WIDTH +: WIDTH];
      end else begin
         for (int w = 0; w < NW; w++) begin
            if (bus.wr_en[w] && !(ZERO_REG0 && bus.wr_addr[w*AW +: AW] == '0))
               regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*WIDTH +: WIDTH];
         end
      end
   end

   reg_file_mp_scoreboard #(
      .DEPTH     (DEPTH),
      .AW        (AW),
      .NW        (NW),
      .ZERO_REG0 (ZERO_REG0)
   ) u_sb (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (bus.wr_en),
      .wr_addr     (bus.wr_addr),
      .sb_set_en   (bus.sb_set_en),
      .sb_set_addr (bus.sb_set_addr),
      .busy        (busy),
      .any_busy    (bus.any_busy)
   );

   for (genvar p = 0; p < NR; p++) begin : g_rd
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] data;
      logic             bsy;
      logic             hit;

      assign addr = bus.rd_addr[p*AW +: AW];

      // A forwarded write retires the pending producer, unless a new one issues this cycle.
      always_comb begin
         data = regs[addr];
         bsy  = busy[addr];
         hit  = 1'b0;
         if (BYPASS) begin
            for (int w = 0; w < NW; w++) begin
               if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == addr) begin
                  data = bus.wr_data[w*WIDTH +: WIDTH];
                  hit  = 1'b1;
               end
            end
            if (hit && !(bus.sb_set_en && bus.sb_set_addr == addr)) bsy = 1'b0;
         end
         if (ZERO_REG0 && addr == '0) begin
            data = '0;
            bsy  = 1'b0;
         end
      end

      assign bus.rd_data[p*WIDTH +: WIDTH] = data;
      assign bus.rd_busy[p]                = bsy;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench driving bypass, non-bypass and zero-register variants with shared stimulus.
module tb_reg_file_mp;
   import reg_file_mp_pkg::*;

   localparam int W  = 16;
   localparam int AW = 4;
   localparam logic [255:0] RST_V = (256'h0F00 << 16) | (256'hA5A5 << 48) | (256'h4004 << 64);

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rd_addr;
   logic [1:0]  wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        sb_set_en;
   logic [3:0]  sb_set_addr;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   reg_file_mp_if #(.WIDTH(W), .AW(AW), .NR(2), .NW(2)) if_byp ();
   reg_file_mp_if #(.WIDTH(W), .AW(AW), .NR(2), .NW(2)) if_nob ();
   reg_file_mp_if #(.WIDTH(W), .AW(AW), .NR(2), .NW(2)) if_z0 ();

   assign if_byp.rd_addr = rd_addr;  assign if_byp.wr_en = wr_en;  assign if_byp.wr_addr = wr_addr;
   assign if_byp.wr_data = wr_data;  assign if_byp.sb_set_en = sb_set_en;  assign if_byp.sb_set_addr = sb_set_addr;
   assign if_nob.rd_addr = rd_addr;  assign if_nob.wr_en = wr_en;  assign if_nob.wr_addr = wr_addr;
   assign if_nob.wr_data = wr_data;  assign if_nob.sb_set_en = sb_set_en;  assign if_nob.sb_set_addr = sb_set_addr;
   assign if_z0.rd_addr  = rd_addr;  assign if_z0.wr_en  = wr_en;  assign if_z0.wr_addr  = wr_addr;
   assign if_z0.wr_data  = wr_data;  assign if_z0.sb_set_en  = sb_set_en;  assign if_z0.sb_set_addr  = sb_set_addr;

   reg_file_mp #(.BYPASS(1'b1), .ZERO_REG0(1'b0), .RST_VALS(RST_V)) u_byp (.clk(clk), .rst(rst), .bus(if_byp));
   reg_file_mp #(.BYPASS(1'b0), .ZERO_REG0(1'b0), .RST_VALS(RST_V)) u_nob (.clk(clk), .rst(rst), .bus(if_nob));
   reg_file_mp #(.BYPASS(1'b1), .ZERO_REG0(1'b1), .RST_VALS(RST_V)) u_z0  (.clk(clk), .rst(rst), .bus(if_z0));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 2'b00; wr_addr = '0; wr_data = '0; sb_set_en = 1'b0; sb_set_addr = '0;
   endtask

   initial begin
      rst = 1'b1;
      rd_addr = '0;
      idle();
      step();
      step();
      rst = 1'b0;

      // reset contents and idle scoreboard
      rd_addr = {4'd4, 4'd1};
      #1;
      chk("rst_rd0_byp", if_byp.rd_data[15:0], 16'h0F00);
      chk("rst_rd1_byp", if_byp.rd_data[31:16], 16'h4004);
      chk("rst_rd0_nob", if_nob.rd_data[15:0], 16'h0F00);
      chk("rst_busy_byp", if_byp.rd_busy, 2'b00);
      chk("rst_any_byp", if_byp.any_busy, 1'b0);

      // two ports collide on reg 5
      step();
      wr_en = 2'b11; wr_addr = {4'd5, 4'd5}; wr_data = {16'h2222, 16'h1111};
      rd_addr = {4'd4, 4'd5};
      #1;
      chk("coll_byp_same", if_byp.rd_data[15:0], 16'h2222);
      chk("coll_nob_same", if_nob.rd_data[15:0], 16'h0000);
      step();
      idle();
      #1;
      chk("coll_byp_next", if_byp.rd_data[15:0], 16'h2222);
      chk("coll_nob_next", if_nob.rd_data[15:0], 16'h2222);
      chk("coll_other", if_nob.rd_data[31:16], 16'h4004);

      // bypass vs stored value on reg 3
      wr_en = 2'b01; wr_addr = {4'd0, 4'd3}; wr_data = {16'h0000, 16'hABCD};
      rd_addr = {4'd3, 4'd3};
      #1;
      chk("byp_rd0", if_byp.rd_data[15:0], 16'hABCD);
      chk("byp_rd1", if_byp.rd_data[31:16], 16'hABCD);
      chk("nob_old", if_nob.rd_data[15:0], 16'hA5A5);
      step();
      idle();
      #1;
      chk("nob_new", if_nob.rd_data[15:0], 16'hABCD);

      // scoreboard on reg 7
      sb_set_en = 1'b1; sb_set_addr = 4'd7; rd_addr = {4'd0, 4'd7};
      #1;
      chk("sb_set_same", if_byp.rd_busy[0], 1'b0);
      step();
      idle();
      #1;
      chk("sb_busy", if_byp.rd_busy[0], 1'b1);
      chk("sb_any", if_byp.any_busy, 1'b1);
      wr_en = 2'b10; wr_addr = {4'd7, 4'd0}; wr_data = {16'h7777, 16'h0000};
      #1;
      chk("sb_fwd_clear", if_byp.rd_busy[0], 1'b0);
      chk("sb_fwd_data", if_byp.rd_data[15:0], 16'h7777);
      chk("sb_nob_busy", if_nob.rd_busy[0], 1'b1);
      step();
      idle();
      #1;
      chk("sb_clr", if_nob.rd_busy[0], 1'b0);
      chk("sb_clr_any", if_nob.any_busy, 1'b0);
      sb_set_en = 1'b1; sb_set_addr = 4'd7;
      step();
      wr_en = 2'b01; wr_addr = {4'd0, 4'd7}; wr_data = {16'h0000, 16'h1234};
      #1;
      chk("sb_setwr_fwd", if_byp.rd_busy[0], 1'b1);
      chk("sb_setwr_data", if_byp.rd_data[15:0], 16'h1234);
      step();
      idle();
      #1;
      chk("sb_setwr_busy", if_nob.rd_busy[0], 1'b1);
      chk("sb_setwr_any", if_nob.any_busy, 1'b1);
      wr_en = 2'b01; wr_addr = {4'd0, 4'd7};
      step();
      idle();

      // writes and sets to register 0
      wr_en = 2'b01; wr_addr = {4'd0, 4'd0}; wr_data = {16'h0000, 16'hFFFF};
      sb_set_en = 1'b1; sb_set_addr = 4'd0; rd_addr = {4'd0, 4'd0};
      #1;
      chk("z0_same", if_z0.rd_data[15:0], 16'h0000);
      step();
      idle();
      #1;
      chk("z0_rd", if_z0.rd_data[15:0], 16'h0000);
      chk("z0_busy", if_z0.rd_busy[0], 1'b0);
      chk("z0_any", if_z0.any_busy, 1'b0);
      chk("nz0_rd", if_byp.rd_data[15:0], 16'hFFFF);
      chk("nz0_busy", if_byp.rd_busy[0], 1'b1);

      // reset with pending set and write on reg 4
      sb_set_en = 1'b1; sb_set_addr = 4'd4; rd_addr = {4'd4, 4'd3};
      step();
      idle();
      #1;
      chk("pre_rst_busy4", if_byp.rd_busy[1], 1'b1);
      rst = 1'b1;
      wr_en = 2'b01; wr_addr = {4'd0, 4'd4}; wr_data = {16'h0000, 16'hDEAD};
      sb_set_en = 1'b1; sb_set_addr = 4'd4;
      step();
      rst = 1'b0;
      idle();
      #1;
      chk("rst_mid_rd4", if_nob.rd_data[31:16], 16'h4004);
      chk("rst_mid_rd3", if_nob.rd_data[15:0], 16'hA5A5);
      chk("rst_mid_busy4", if_byp.rd_busy[1], 1'b0);
      chk("rst_mid_any", if_byp.any_busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
